regbank512_n: RTL and testbench

512-entry, n-bit register bank that sources the 512:1 read-select stage. Exposes every stored word in parallel (data_o array) for the downstream mux512to1_n, and provides:
- a single write port with ready/ack handshake,
- a hardware clear engine that sweeps all entries,
- a registered single-word read port built on mux512to1_n.

---
 rtl/regbank512_n_if.sv | 33 +++
 rtl/regbank512_n.sv | 129 ++++++++++++
 tb/tb_regbank512_n.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regbank512_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regbank512_n_if                                                 |
// | Purpose  : Write/clear/read bus and parallel word view of regbank512_n.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface regbank512_n_if #(
  parameter int N       = 4,
  parameter int ADDRESS = 9,
  parameter int M       = 2 ** ADDRESS
);
  logic               wr_en_i;
  logic [ADDRESS-1:0] wr_addr_i;
  logic [N-1:0]       wr_data_i;
  logic               wr_ready_o;
  logic               wr_ack_o;
  logic               clear_i;
  logic               busy_o;
  logic [ADDRESS-1:0] rd_addr_i;
  logic [N-1:0]       rd_data_o;
  logic [N-1:0]       data_o [0:M-1];

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, clear_i, rd_addr_i,
    input  wr_ready_o, wr_ack_o, busy_o, rd_data_o, data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, clear_i, rd_addr_i,
    output wr_ready_o, wr_ack_o, busy_o, rd_data_o, data_o
  );
endinterface
`default_nettype wire

// File: rtl/regbank512_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regbank512_n (with helper mux512to1_n)                          |
// | Purpose  : 512 x N register bank, handshaked write, sweep-clear engine,    |
// |            registered read. Define REGBANK_INIT_CLEAR_EN to auto-clear     |
// |            the bank out of reset.                                          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mux512to1_n #(
  parameter int N       = 4,
  parameter int ADDRESS = 9,
  parameter int M       = 2 ** ADDRESS
) (
  input  wire logic [N-1:0]       i_data [0:M-1],
  input  wire logic [ADDRESS-1:0] i_sel,
  output logic      [N-1:0]       o_data
);
  assign o_data = i_data[i_sel];
endmodule

module regbank512_n #(
  parameter int N       = 4,
  parameter int ADDRESS = 9,
  parameter int M       = 2 ** ADDRESS
) (
  input wire logic      clk_i,
  input wire logic      rst_ni,
  regbank512_n_if.slave bus
);
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDRESS-1:0] c_LAST = ADDRESS'(M - 1);

`ifdef REGBANK_INIT_CLEAR_EN
  localparam state_t c_RST_STATE = S_CLEAR;
  localparam logic   c_RST_BUSY  = 1'b1;
`else
  localparam state_t c_RST_STATE = S_IDLE;
  localparam logic   c_RST_BUSY  = 1'b0;
`endif

  state_t             r_state;
  logic [ADDRESS-1:0] r_cnt;
  logic               r_busy;
  logic               r_wr_ready;
  logic               r_wr_ack;
  logic [N-1:0]       r_rd_data;
  logic [N-1:0]       r_mem [0:M-1];
  logic [N-1:0]       w_rd_mux;
  logic               w_wr_accept;

  assign w_wr_accept = bus.wr_en_i & r_wr_ready;

  // Control FSM; busy/ready are registered alongside the state so they never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= c_RST_STATE;
      r_cnt      <= '0;
      r_busy     <= c_RST_BUSY;
      r_wr_ready <= ~c_RST_BUSY;
      r_wr_ack   <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_accept;
      case (r_state)
        S_IDLE: begin
          if (bus.clear_i) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (bus.clear_i) begin
            r_cnt <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage is deliberately unreset; writes are impossible while sweeping.
  always_ff @(posedge clk_i) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_accept) begin
      r_mem[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  mux512to1_n #(
    .N       (N),
    .ADDRESS (ADDRESS),
    .M       (M)
  ) u_rd_mux (
    .i_data (r_mem),
    .i_sel  (bus.rd_addr_i),
    .o_data (w_rd_mux)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_mux;
    end
  end

  assign bus.wr_ready_o = r_wr_ready;
  assign bus.wr_ack_o   = r_wr_ack;
  assign bus.busy_o     = r_busy;
  assign bus.rd_data_o  = r_rd_data;
  assign bus.data_o     = r_mem;
endmodule
`default_nettype wire

// File: tb/tb_regbank512_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_regbank512_n                                                 |
// | Purpose  : Scoreboard bench for regbank512_n against a reference model.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_regbank512_n;
  localparam int N       = 4;
  localparam int ADDRESS = 9;
  localparam int M       = 512;
`ifdef REGBANK_INIT_CLEAR_EN
  localparam bit c_INIT = 1'b1;
`else
  localparam bit c_INIT = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  regbank512_n_if #(.N(N), .ADDRESS(ADDRESS), .M(M)) bus ();

  regbank512_n #(.N(N), .ADDRESS(ADDRESS), .M(M)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] rd;
    bit           rd_known;
    bit           ack;
    bit           busy;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: word array with known flags and a sweep position.
  logic [N-1:0] m_mem   [0:M-1];
  bit           m_known [0:M-1];
  bit           m_busy;
  int           m_pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (!rst_ni) begin
      e.rd = '0; e.rd_known = 1'b1; e.ack = 1'b0;
      if (c_INIT) begin
        m_mem[0] = '0; m_known[0] = 1'b1; m_busy = 1'b1; m_pos = 0;
      end else begin
        m_busy = 1'b0;
      end
      e.busy = m_busy;
      sb_q.push_back(e);
      return;
    end
    e.rd       = m_mem[bus.rd_addr_i];
    e.rd_known = m_known[bus.rd_addr_i];
    e.ack      = bus.wr_en_i && !m_busy;
    if (!m_busy) begin
      if (e.ack) begin
        m_mem[bus.wr_addr_i] = bus.wr_data_i;
        m_known[bus.wr_addr_i] = 1'b1;
      end
      if (bus.clear_i) begin m_busy = 1'b1; m_pos = 0; end
    end else begin
      m_mem[m_pos] = '0;
      m_known[m_pos] = 1'b1;
      if (bus.clear_i) m_pos = 0;
      else if (m_pos == M - 1) m_busy = 1'b0;
      else m_pos++;
    end
    e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  // Called at posedge+4; returns at the next posedge+4.
  task automatic cycle(input bit we, input logic [ADDRESS-1:0] wa, input logic [N-1:0] wd,
                       input bit clr, input logic [ADDRESS-1:0] ra);
    bus.wr_en_i   = we;
    bus.wr_addr_i = wa;
    bus.wr_data_i = wd;
    bus.clear_i   = clr;
    bus.rd_addr_i = ra;
    model_step();
    @(posedge clk_i);
    #4;
  endtask

  function automatic logic [ADDRESS-1:0] ra_rand();
    return ADDRESS'($urandom_range(0, M - 1));
  endfunction

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, ra_rand());
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (bus.busy_o && n < 2000) begin
      n++;
      idle();
    end
  endtask

  task automatic check_mem(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < M; i++)
      if (bad < 0 && m_known[i] && bus.data_o[i] !== m_mem[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s data_o[%0d] actual=%0h expected=%0h", name, bad, bus.data_o[bad], m_mem[bad]);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.rd_known) check("sb_rd_data", 32'(bus.rd_data_o), 32'(e.rd));
        check("sb_wr_ack", 32'(bus.wr_ack_o), 32'(e.ack));
        check("sb_busy", 32'(bus.busy_o), 32'(e.busy));
        check("sb_wr_ready", 32'(bus.wr_ready_o), 32'(!e.busy));
      end
    end
  end

  initial begin : stim
    int n;
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
    bus.clear_i = 1'b0; bus.rd_addr_i = '0;
    for (int i = 0; i < M; i++) begin m_mem[i] = '0; m_known[i] = 1'b0; end
    m_busy = c_INIT; m_pos = 0;
    repeat (2) @(posedge clk_i);
    #4;
    check("rst_rd_data", 32'(bus.rd_data_o), 32'd0);
    check("rst_wr_ack", 32'(bus.wr_ack_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'(c_INIT));
    check("rst_wr_ready", 32'(bus.wr_ready_o), 32'(!c_INIT));
    idle(); idle();
    rst_ni = 1'b1;

    if (!c_INIT) cycle(1'b0, '0, '0, 1'b1, ra_rand());
    run_busy(n);
    check("first_sweep_len", 32'(n), 32'd512);
    check_mem("first_sweep_zero");
    check("first_sweep_rd", 32'(bus.rd_data_o), 32'd0);

    cycle(1'b1, 9'h1A5, 4'hC, 1'b0, ra_rand());
    check("t2_ack", 32'(bus.wr_ack_o), 32'd1);
    check("t2_data_o_421", 32'(bus.data_o[421]), 32'hC);
    cycle(1'b0, '0, '0, 1'b0, 9'h1A5);
    check("t2_ack_one_cycle", 32'(bus.wr_ack_o), 32'd0);
    check("t2_rd", 32'(bus.rd_data_o), 32'hC);

    cycle(1'b1, 9'd7, 4'h9, 1'b0, ra_rand());
    cycle(1'b1, 9'd7, 4'h3, 1'b0, 9'd7);
    check("t3_rd_old", 32'(bus.rd_data_o), 32'h9);
    cycle(1'b0, '0, '0, 1'b0, 9'd7);
    check("t3_rd_new", 32'(bus.rd_data_o), 32'h3);

    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 1)), ra_rand(), N'($urandom_range(0, 15)), 1'b0, ra_rand());
    check_mem("random_phase");

    for (int i = 0; i < M; i++) cycle(1'b1, ADDRESS'(i), N'(i % 16), 1'b0, ra_rand());
    check_mem("t4_fill");
    cycle(1'b1, 9'd5, 4'hA, 1'b1, ra_rand());
    n = 0;
    while (bus.busy_o && n < 2000) begin
      n++;
      cycle(1'b1, 9'h33, 4'h6, 1'b0, ra_rand());
    end
    check("t4_sweep_len", 32'(n), 32'd512);
    cycle(1'b1, 9'h33, 4'h6, 1'b0, 9'd5);
    check("t4_first_ack", 32'(bus.wr_ack_o), 32'd1);
    check("t4_entry5_swept", 32'(bus.rd_data_o), 32'd0);
    check_mem("t4_cleared");

    cycle(1'b1, 9'd0, 4'hF, 1'b0, ra_rand());
    cycle(1'b0, '0, '0, 1'b1, ra_rand());
    n = 0;
    while (bus.busy_o && n < 2000) begin
      n++;
      cycle(1'b0, '0, '0, (n == 300), ra_rand());
    end
    check("t5_restart_len", 32'(n), 32'd812);
    check("t5_entry0", 32'(bus.data_o[0]), 32'd0);
    check_mem("t5_mem");

    for (int i = 0; i < M; i++) cycle(1'b1, ADDRESS'(i), N'((i * 7 + 3) % 16), 1'b0, ra_rand());
    cycle(1'b0, '0, '0, 1'b1, ra_rand());
    repeat (100) idle();
    rst_ni = 1'b0;
    #1;
    check("t6_busy", 32'(bus.busy_o), 32'(c_INIT));
    check("t6_wr_ready", 32'(bus.wr_ready_o), 32'(!c_INIT));
    check("t6_rd_data", 32'(bus.rd_data_o), 32'd0);
    m_busy = c_INIT; m_pos = 0;
    idle();
    rst_ni = 1'b1;
    check("t6_entry99", 32'(bus.data_o[99]), 32'd0);
    check("t6_entry100", 32'(bus.data_o[100]), 32'((100 * 7 + 3) % 16));
    check_mem("t6_partial");
    run_busy(n);
    for (int k = 0; k < 50; k++)
      cycle(1'($urandom_range(0, 1)), ra_rand(), N'($urandom_range(0, 15)), 1'b0, ra_rand());
    check_mem("final_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
